// File: rtl/pswd_pkg.sv
// pswd_pkg: shared sizes, FSM state encoding and slot check for the password store.
`default_nettype none

package pswd_pkg;

  localparam int DIGITS    = 6;
  localparam int DIG_W     = 4;
  localparam int PSWD_W    = DIGITS * DIG_W;
  localparam int ADDR_W    = 5;
  localparam int NUM_USERS = 5;
  localparam int CNT_W     = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GET_NEW     = 3'd1,
    S_GET_CONFIRM = 3'd2,
    S_COMPARE     = 3'd3,
    S_WRITE       = 3'd4,
    S_SETTLE      = 3'd5,
    S_DONE        = 3'd6,
    S_FAIL        = 3'd7
  } state_t;

  function automatic logic id_valid(input logic [ADDR_W-1:0] id);
    return id < ADDR_W'(NUM_USERS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pswd_digit_collector.sv
// pswd_digit_collector: packs DIGITS hex digits MSB-first into one password word.
`default_nettype none

module pswd_digit_collector
  import pswd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic [DIG_W-1:0]  i_digit,
  output logic [PSWD_W-1:0] o_value,
  output logic              o_last,
  output logic              o_full
);

  logic [CNT_W-1:0]  r_count;
  logic [PSWD_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
      r_value <= '0;
    end else if (i_capture && !o_full) begin
      // Shifting left leaves the first digit in the top nibble after the last capture.
      r_value <= {r_value[PSWD_W-DIG_W-1:0], i_digit};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_last  = (r_count == CNT_W'(DIGITS - 1));
  assign o_full  = (r_count == CNT_W'(DIGITS));

endmodule

`default_nettype wire

// File: rtl/pswd_writer.sv
// pswd_writer: collects a new password twice, confirms it and writes it to the user's RAM slot.
`default_nettype none

module pswd_writer
  import pswd_pkg::*;
#(
  parameter int WR_SETTLE = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Authenticated,
  input  logic              BeginChange,
  input  logic              EnterPswd,
  input  logic [DIG_W-1:0]  InputSwitches,
  input  logic              CancelPulse,
  input  logic [ADDR_W-1:0] InternalID,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [PSWD_W-1:0] WrData,
  output logic              Busy,
  output logic              ChangeDone,
  output logic              ChangeFail
);

  localparam int SET_W = $clog2(WR_SETTLE + 2);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_id;
  logic [SET_W-1:0]  r_settle;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PSWD_W-1:0] r_wr_data;

  logic              w_clear;
  logic              w_cap_new;
  logic              w_cap_conf;
  logic              w_abort;
  logic [PSWD_W-1:0] w_new_pswd;
  logic [PSWD_W-1:0] w_conf_pswd;
  logic              w_new_last;
  logic              w_new_full;
  logic              w_conf_last;
  logic              w_conf_full;

  pswd_digit_collector u_new (
    .clk       (Clk),
    .rst       (Reset),
    .i_clear   (w_clear),
    .i_capture (w_cap_new),
    .i_digit   (InputSwitches),
    .o_value   (w_new_pswd),
    .o_last    (w_new_last),
    .o_full    (w_new_full)
  );

  pswd_digit_collector u_conf (
    .clk       (Clk),
    .rst       (Reset),
    .i_clear   (w_clear),
    .i_capture (w_cap_conf),
    .i_digit   (InputSwitches),
    .o_value   (w_conf_pswd),
    .o_last    (w_conf_last),
    .o_full    (w_conf_full)
  );

  assign w_abort = CancelPulse || !Authenticated;

  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_cap_new  = 1'b0;
    w_cap_conf = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (BeginChange && Authenticated) begin
          w_next  = S_GET_NEW;
          w_clear = 1'b1;
        end
      end
      // Abort is checked before capture so a same-edge cancel discards the digit.
      S_GET_NEW: begin
        if (w_abort) begin
          w_next = S_FAIL;
        end else if (EnterPswd) begin
          w_cap_new = 1'b1;
          if (w_new_last) w_next = S_GET_CONFIRM;
        end
      end
      S_GET_CONFIRM: begin
        if (w_abort) begin
          w_next = S_FAIL;
        end else if (EnterPswd) begin
          w_cap_conf = 1'b1;
          if (w_conf_last) w_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!w_abort && w_new_full && w_conf_full &&
            (w_new_pswd == w_conf_pswd) && id_valid(r_id))
          w_next = S_WRITE;
        else
          w_next = S_FAIL;
      end
      S_WRITE:  w_next = S_SETTLE;
      S_SETTLE: if (r_settle <= SET_W'(1)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_FAIL:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_id      <= '0;
      r_settle  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_GET_NEW) r_id <= InternalID;
      if (r_state == S_WRITE)
        r_settle <= SET_W'(WR_SETTLE);
      else if (r_state == S_SETTLE && r_settle != '0)
        r_settle <= r_settle - SET_W'(1);
      if (w_next == S_WRITE) begin
        r_wr_addr <= r_id;
        r_wr_data <= w_new_pswd;
      end
    end
  end

  assign WrEn       = (r_state == S_WRITE);
  assign WrAddr     = r_wr_addr;
  assign WrData     = r_wr_data;
  assign Busy       = (r_state != S_IDLE);
  assign ChangeDone = (r_state == S_DONE);
  assign ChangeFail = (r_state == S_FAIL);

endmodule

`default_nettype wire

// File: tb/tb_pswd_writer.sv
// tb_pswd_writer: directed sequence with write/outcome scoreboard queues for pswd_writer.
`default_nettype none

module tb_pswd_writer;

  logic        Clk;
  logic        Reset;
  logic        Authenticated;
  logic        BeginChange;
  logic        EnterPswd;
  logic [3:0]  InputSwitches;
  logic        CancelPulse;
  logic [4:0]  InternalID;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [23:0] WrData;
  logic        Busy;
  logic        ChangeDone;
  logic        ChangeFail;

  typedef struct {
    logic [4:0]  addr;
    logic [23:0] data;
  } wr_t;

  wr_t  wq[$];
  logic oq[$];
  int   vectors = 0;
  int   fails   = 0;

  pswd_writer #(.WR_SETTLE(2)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Authenticated (Authenticated),
    .BeginChange   (BeginChange),
    .EnterPswd     (EnterPswd),
    .InputSwitches (InputSwitches),
    .CancelPulse   (CancelPulse),
    .InternalID    (InternalID),
    .WrEn          (WrEn),
    .WrAddr        (WrAddr),
    .WrData        (WrData),
    .Busy          (Busy),
    .ChangeDone    (ChangeDone),
    .ChangeFail    (ChangeFail)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then retire any write or outcome the DUT produced against the queues.
  task automatic tick();
    wr_t  w;
    logic o;
    @(posedge Clk);
    #1;
    if (WrEn === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_wren", {31'd0, WrEn}, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {27'd0, WrAddr}, {27'd0, w.addr});
        chk("wr_data", {8'd0, WrData}, {8'd0, w.data});
      end
    end
    if (ChangeDone === 1'b1 || ChangeFail === 1'b1) begin
      chk("done_fail_excl", {31'd0, ChangeDone & ChangeFail}, 32'd0);
      if (oq.size() == 0) begin
        chk("unexpected_outcome", {31'd0, ChangeDone | ChangeFail}, 32'd0);
      end else begin
        o = oq.pop_front();
        chk("outcome_kind", {31'd0, ChangeDone}, {31'd0, o});
      end
    end
  endtask

  task automatic enter(input logic [3:0] d);
    InputSwitches = d;
    EnterPswd     = 1'b1;
    tick();
    EnterPswd     = 1'b0;
  endtask

  task automatic begin_change(input logic [4:0] id);
    InternalID  = id;
    BeginChange = 1'b1;
    tick();
    BeginChange = 1'b0;
    InternalID  = ~id;
  endtask

  task automatic do_change(input logic [4:0] id, input logic [23:0] npw, input logic [23:0] cpw);
    logic ok;
    ok = (npw == cpw) && (id < 5'd5);
    if (ok) wq.push_back('{id, npw});
    oq.push_back(ok);
    begin_change(id);
    for (int i = 0; i < 6; i++) enter(npw[23-4*i -: 4]);
    for (int i = 0; i < 6; i++) enter(cpw[23-4*i -: 4]);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((oq.size() != 0 || Busy !== 1'b0) && n < bound) begin
      tick();
      n++;
    end
    chk("outcome_timeout", oq.size(), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Authenticated = 1'b0; BeginChange = 1'b0; EnterPswd = 1'b0;
    InputSwitches = 4'h0; CancelPulse = 1'b0; InternalID = 5'd0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_wren", {31'd0, WrEn}, 32'd0);
    chk("rst_wraddr", {27'd0, WrAddr}, 32'd0);
    chk("rst_wrdata", {8'd0, WrData}, 32'd0);

    // Matching change for slot 2, with exact latency to ChangeDone
    Authenticated = 1'b1;
    do_change(5'd2, 24'hA54E32, 24'hA54E32);
    chk("cmp_busy", {31'd0, Busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_early", {31'd0, ChangeDone}, 32'd0);
    end
    chk("settle_wren_low", {31'd0, WrEn}, 32'd0);
    chk("settle_addr_held", {27'd0, WrAddr}, 32'd2);
    chk("settle_data_held", {8'd0, WrData}, 32'hA54E32);
    tick();
    chk("done_latency", {31'd0, ChangeDone}, 32'd1);
    tick();
    chk("idle_after_done", {31'd0, Busy}, 32'd0);

    // Reset held two cycles in the middle of GetConfirm
    begin_change(5'd1);
    for (int i = 0; i < 8; i++) enter(4'(i));
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_wraddr", {27'd0, WrAddr}, 32'd0);
    chk("midrst_wrdata", {8'd0, WrData}, 32'd0);
    chk("midrst_flags", {29'd0, WrEn, ChangeDone, ChangeFail}, 32'd0);
    tick();
    chk("midrst_stays_idle", {31'd0, Busy}, 32'd0);

    // Mismatch, then an out-of-range slot with matching digits
    do_change(5'd3, 24'hEEE420, 24'hEEE421);
    wait_idle(20);
    do_change(5'd7, 24'hF24630, 24'hF24630);
    wait_idle(20);
    do_change(5'd5, 24'h000001, 24'h000001);
    wait_idle(20);

    // Cancel and digit on the same edge after three digits
    oq.push_back(1'b0);
    begin_change(5'd0);
    for (int i = 0; i < 3; i++) enter(4'hC);
    InputSwitches = 4'h9; EnterPswd = 1'b1; CancelPulse = 1'b1;
    tick();
    EnterPswd = 1'b0; CancelPulse = 1'b0;
    chk("cancel_fail_next", {31'd0, ChangeFail}, 32'd1);
    wait_idle(10);

    // Authentication lost during GetNew
    oq.push_back(1'b0);
    begin_change(5'd1);
    enter(4'h1);
    enter(4'h2);
    Authenticated = 1'b0;
    tick();
    chk("deauth_fail", {31'd0, ChangeFail}, 32'd1);
    wait_idle(10);

    // BeginChange while not authenticated is ignored
    BeginChange = 1'b1;
    tick();
    BeginChange = 1'b0;
    chk("unauth_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("unauth_busy2", {31'd0, Busy}, 32'd0);

    // Cancel during Settle cannot stop a started write
    Authenticated = 1'b1;
    do_change(5'd4, 24'h123456, 24'h123456);
    tick();
    tick();
    CancelPulse = 1'b1;
    tick();
    CancelPulse = 1'b0;
    chk("settle_cancel_nofail", {31'd0, ChangeFail}, 32'd0);
    chk("settle_cancel_addr", {27'd0, WrAddr}, 32'd4);
    tick();
    chk("settle_cancel_done", {31'd0, ChangeDone}, 32'd1);
    wait_idle(10);

    chk("writes_outstanding", wq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
